// File: rtl/spiral_reorder.sv
// -----------------------------------------------------------------------------
// spiral_reorder
//
// Matrix reorder buffer. It accepts one row-major frame of up to
// (2^R_WIDTH-1) x (2^C_WIDTH-1) elements, stores the whole frame, and then
// replays it in a selectable order: raster, clockwise spiral,
// counter-clockwise spiral or transpose (column-major). Input and output
// phases of consecutive frames never overlap.
//
// Ports
//   clk            : clock, all logic on the rising edge
//   rst            : asynchronous, active-high reset
//   row, col       : frame dimensions, sampled on the first accepted beat
//   mode           : 0 raster, 1 clockwise, 2 counter-clockwise, 3 transpose
//   data_in        : row-major input element
//   data_in_valid  : input beat valid
//   data_in_rdy    : block can accept an input beat
//   data_out       : reordered element (0 when not draining)
//   data_out_valid : output beat valid
//   data_out_rdy   : consumer accepts the output beat
//   data_out_last  : marks the final output beat of a frame
//   busy           : high while loading or draining
// -----------------------------------------------------------------------------
module spiral_reorder #(
    parameter int DATA_WIDTH = 8,
    parameter int R_WIDTH    = 3,
    parameter int C_WIDTH    = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [R_WIDTH-1:0]    row,
    input  logic [C_WIDTH-1:0]    col,
    input  logic [1:0]            mode,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  data_in_valid,
    output logic                  data_in_rdy,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_out_valid,
    input  logic                  data_out_rdy,
    output logic                  data_out_last,
    output logic                  busy
);

    localparam int AW    = R_WIDTH + C_WIDTH;
    localparam int DEPTH = ((1 << R_WIDTH) - 1) * ((1 << C_WIDTH) - 1);

    localparam logic [R_WIDTH-1:0] R_ONE = R_WIDTH'(1);
    localparam logic [C_WIDTH-1:0] C_ONE = C_WIDTH'(1);
    localparam logic [AW-1:0]      A_ONE = AW'(1);

    localparam logic [1:0] MODE_RASTER    = 2'd0;
    localparam logic [1:0] MODE_CW        = 2'd1;
    localparam logic [1:0] MODE_CCW       = 2'd2;
    localparam logic [1:0] MODE_TRANSPOSE = 2'd3;

    typedef enum logic [1:0] {IDLE, LOAD, DRAIN} state_e;
    typedef enum logic [1:0] {DIR_RIGHT, DIR_DOWN, DIR_LEFT, DIR_UP} dir_e;

    state_e               state_q, state_d;
    logic [R_WIDTH-1:0]   row_q, row_d;
    logic [C_WIDTH-1:0]   col_q, col_d;
    logic [1:0]           mode_q, mode_d;
    logic [AW-1:0]        cnt_q, cnt_d;      // load beat index, then drain beat index
    logic [R_WIDTH-1:0]   r_q, r_d;          // drain read position
    logic [C_WIDTH-1:0]   c_q, c_d;
    logic [R_WIDTH-1:0]   top_q, top_d, bot_q, bot_d;
    logic [C_WIDTH-1:0]   left_q, left_d, right_q, right_d;
    dir_e                 dir_q, dir_d;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic                  wr_en;
    logic [AW-1:0]         wr_addr;
    logic [AW-1:0]         rd_addr;
    logic [AW-1:0]         last_idx;
    logic                  in_accept;
    logic                  out_xfer;
    logic                  at_edge;
    dir_e                  next_dir;

    assign last_idx = AW'(row_q) * AW'(col_q) - A_ONE;
    assign rd_addr  = AW'(r_q) * AW'(col_q) + AW'(c_q);

    assign data_in_rdy    = !rst && (state_q == LOAD ||
                                     (state_q == IDLE && row != '0 && col != '0));
    assign data_out_valid = (state_q == DRAIN);
    assign data_out       = (state_q == DRAIN) ? mem_q[rd_addr] : '0;
    assign data_out_last  = (state_q == DRAIN) && (cnt_q == last_idx);
    assign busy           = (state_q != IDLE);

    assign in_accept = data_in_valid && data_in_rdy;
    assign out_xfer  = data_out_valid && data_out_rdy;

    // A spiral segment ends when the position reaches the bound it is heading for.
    always_comb begin
        unique case (dir_q)
            DIR_RIGHT: at_edge = (c_q == right_q);
            DIR_DOWN:  at_edge = (r_q == bot_q);
            DIR_LEFT:  at_edge = (c_q == left_q);
            default:   at_edge = (r_q == top_q);
        endcase
    end

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned; a missing default here would infer a latch.
        state_d  = state_q;
        row_d    = row_q;
        col_d    = col_q;
        mode_d   = mode_q;
        cnt_d    = cnt_q;
        r_d      = r_q;
        c_d      = c_q;
        top_d    = top_q;
        bot_d    = bot_q;
        left_d   = left_q;
        right_d  = right_q;
        dir_d    = dir_q;
        next_dir = dir_q;
        wr_en    = 1'b0;
        wr_addr  = cnt_q;

        unique case (state_q)
            IDLE: begin
                if (in_accept) begin
                    row_d   = row;
                    col_d   = col;
                    mode_d  = mode;
                    wr_en   = 1'b1;
                    wr_addr = '0;
                    // The read generator is armed now so a 1x1 frame can drain at once.
                    r_d     = '0;
                    c_d     = '0;
                    top_d   = '0;
                    bot_d   = row - R_ONE;
                    left_d  = '0;
                    right_d = col - C_ONE;
                    dir_d   = (mode == MODE_CCW) ? DIR_DOWN : DIR_RIGHT;
                    if (row == R_ONE && col == C_ONE) begin
                        state_d = DRAIN;
                        cnt_d   = '0;
                    end else begin
                        state_d = LOAD;
                        cnt_d   = A_ONE;
                    end
                end
            end

            LOAD: begin
                if (in_accept) begin
                    wr_en = 1'b1;
                    if (cnt_q == last_idx) begin
                        state_d = DRAIN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + A_ONE;
                    end
                end
            end

            default: begin  // DRAIN
                if (out_xfer) begin
                    if (cnt_q == last_idx) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + A_ONE;
                        unique case (mode_q)
                            MODE_RASTER: begin
                                if (c_q == col_q - C_ONE) begin
                                    c_d = '0;
                                    r_d = r_q + R_ONE;
                                end else begin
                                    c_d = c_q + C_ONE;
                                end
                            end
                            MODE_TRANSPOSE: begin
                                if (r_q == row_q - R_ONE) begin
                                    r_d = '0;
                                    c_d = c_q + C_ONE;
                                end else begin
                                    r_d = r_q + R_ONE;
                                end
                            end
                            default: begin
                                // At a segment end, retire the edge just walked and
                                // turn; the step then goes one cell in the new
                                // direction. The output count ends the frame, so
                                // bounds that wrap past each other are never used.
                                if (at_edge) begin
                                    if (mode_q == MODE_CW) begin
                                        unique case (dir_q)
                                            DIR_RIGHT: begin top_d   = top_q + R_ONE;   next_dir = DIR_DOWN;  end
                                            DIR_DOWN:  begin right_d = right_q - C_ONE; next_dir = DIR_LEFT;  end
                                            DIR_LEFT:  begin bot_d   = bot_q - R_ONE;   next_dir = DIR_UP;    end
                                            default:   begin left_d  = left_q + C_ONE;  next_dir = DIR_RIGHT; end
                                        endcase
                                    end else begin
                                        unique case (dir_q)
                                            DIR_DOWN:  begin left_d  = left_q + C_ONE;  next_dir = DIR_RIGHT; end
                                            DIR_RIGHT: begin bot_d   = bot_q - R_ONE;   next_dir = DIR_UP;    end
                                            DIR_UP:    begin right_d = right_q - C_ONE; next_dir = DIR_LEFT;  end
                                            default:   begin top_d   = top_q + R_ONE;   next_dir = DIR_DOWN;  end
                                        endcase
                                    end
                                end
                                dir_d = next_dir;
                                unique case (next_dir)
                                    DIR_RIGHT: c_d = c_q + C_ONE;
                                    DIR_DOWN:  r_d = r_q + R_ONE;
                                    DIR_LEFT:  c_d = c_q - C_ONE;
                                    default:   r_d = r_q - R_ONE;
                                endcase
                            end
                        endcase
                    end
                end
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            row_q   <= '0;
            col_q   <= '0;
            mode_q  <= '0;
            cnt_q   <= '0;
            r_q     <= '0;
            c_q     <= '0;
            top_q   <= '0;
            bot_q   <= '0;
            left_q  <= '0;
            right_q <= '0;
            dir_q   <= DIR_RIGHT;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            r_q     <= r_d;
            c_q     <= c_d;
            top_q   <= top_d;
            bot_q   <= bot_d;
            left_q  <= left_d;
            right_q <= right_d;
            dir_q   <= dir_d;
        end
    end

    // NOTE: the frame store has no reset; every entry read in a frame is
    // written earlier in that same frame, and a reset port would only widen
    // the array logic.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= data_in;
        end
    end

endmodule

// File: tb/tb_spiral_reorder.sv
// -----------------------------------------------------------------------------
// tb_spiral_reorder
//
// Directed bench for spiral_reorder: loads frames with known data, then checks
// every output beat, the last marker and the handshake/idle behaviour against
// hand-computed traversal orders.
// -----------------------------------------------------------------------------
module tb_spiral_reorder;

    localparam int DW = 8;
    localparam int RW = 3;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [RW-1:0] row;
    logic [CW-1:0] col;
    logic [1:0]    mode;
    logic [DW-1:0] data_in;
    logic          data_in_valid;
    logic          data_in_rdy;
    logic [DW-1:0] data_out;
    logic          data_out_valid;
    logic          data_out_rdy;
    logic          data_out_last;
    logic          busy;

    int tests_run    = 0;
    int tests_failed = 0;
    int q[$];

    always #5 clk = ~clk;

    spiral_reorder #(
        .DATA_WIDTH(DW),
        .R_WIDTH   (RW),
        .C_WIDTH   (CW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .row           (row),
        .col           (col),
        .mode          (mode),
        .data_in       (data_in),
        .data_in_valid (data_in_valid),
        .data_in_rdy   (data_in_rdy),
        .data_out      (data_out),
        .data_out_valid(data_out_valid),
        .data_out_rdy  (data_out_rdy),
        .data_out_last (data_out_last),
        .busy          (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Feeds rows*cols beats of (index ^ key). Returns before the edge that
    // takes the final beat. With scramble set, row/col/mode change after the
    // first accepted beat and must be ignored.
    task automatic load_frame(input int rows, input int cols, input int m,
                              input logic [7:0] key, input bit gaps, input bit scramble);
        int n      = rows * cols;
        int i      = 0;
        int budget = 0;
        row  = RW'(rows);
        col  = CW'(cols);
        mode = 2'(m);
        while (i < n) begin
            @(negedge clk);
            if (scramble && i > 0) begin
                row  = 3'd7;
                col  = 3'd7;
                mode = 2'd1;
            end
            data_in       = 8'(i) ^ key;
            data_in_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            #1;
            check("load_rdy", data_in_rdy, 1);
            if (i > 0) check("load_busy", busy, 1);
            if (data_in_valid && data_in_rdy) i++;
            budget++;
            if (budget > 1000) begin
                check("load_timeout", i, n);
                break;
            end
        end
    endtask

    // Consumes n_take beats, comparing each against exp_q[k] ^ key. While a
    // beat is stalled it is re-checked every cycle, which covers stability.
    task automatic drain(input int exp_q[$], input logic [7:0] key, input bit rnd, input int n_take);
        int k      = 0;
        int budget = 0;
        while (k < n_take) begin
            @(negedge clk);
            data_in_valid = 1'b0;
            data_out_rdy  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (!rnd) check("no_bubble", data_out_valid, 1);
            if (data_out_valid) begin
                check("data", data_out, DW'(exp_q[k]) ^ key);
                check("last", data_out_last, k == exp_q.size() - 1);
                check("rdy_in_drain", data_in_rdy, 0);
                if (data_out_rdy) k++;
            end
            budget++;
            if (budget > 1000) begin
                check("drain_timeout", k, n_take);
                break;
            end
        end
    endtask

    task automatic check_idle();
        @(negedge clk);
        #1;
        check("end_valid", data_out_valid, 0);
        check("end_last", data_out_last, 0);
        check("end_rdy", data_in_rdy, 1);
        check("end_busy", busy, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst           = 1'b1;
        row           = 3'd4;
        col           = 3'd4;
        mode          = 2'd0;
        data_in       = '0;
        data_in_valid = 1'b0;
        data_out_rdy  = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_rdy", data_in_rdy, 0);
        check("rst_valid", data_out_valid, 0);
        check("rst_data", data_out, 0);
        check("rst_last", data_out_last, 0);
        check("rst_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("idle_rdy", data_in_rdy, 1);

        // 4x4 clockwise
        q = '{0, 1, 2, 3, 7, 11, 15, 14, 13, 12, 8, 4, 5, 6, 10, 9};
        load_frame(4, 4, 1, 8'h00, 1'b0, 1'b0);
        drain(q, 8'h00, 1'b0, q.size());
        check_idle();

        // 4x4 counter-clockwise
        q = '{0, 4, 8, 12, 13, 14, 15, 11, 7, 3, 2, 1, 5, 9, 10, 6};
        load_frame(4, 4, 2, 8'h00, 1'b0, 1'b0);
        drain(q, 8'h00, 1'b0, q.size());
        check_idle();

        // 3x5 clockwise
        q = '{0, 1, 2, 3, 4, 9, 14, 13, 12, 11, 10, 5, 6, 7, 8};
        load_frame(3, 5, 1, 8'h00, 1'b0, 1'b0);
        drain(q, 8'h00, 1'b0, q.size());
        check_idle();

        // 4x1 clockwise (single column)
        q = '{0, 1, 2, 3};
        load_frame(4, 1, 1, 8'h00, 1'b0, 1'b0);
        drain(q, 8'h00, 1'b0, q.size());
        check_idle();

        // 1x1: one beat carrying last
        q = '{0};
        load_frame(1, 1, 1, 8'h3c, 1'b0, 1'b0);
        drain(q, 8'h3c, 1'b0, q.size());
        check_idle();

        // 2x3 transpose
        q = '{0, 3, 1, 4, 2, 5};
        load_frame(2, 3, 3, 8'h00, 1'b0, 1'b0);
        drain(q, 8'h00, 1'b0, q.size());
        check_idle();

        // 2x3 raster, dimensions and mode disturbed mid-load
        q = '{0, 1, 2, 3, 4, 5};
        load_frame(2, 3, 0, 8'h00, 1'b0, 1'b1);
        drain(q, 8'h00, 1'b0, q.size());
        check_idle();

        // 7x7 clockwise with input gaps and random output back-pressure
        q = '{ 0,  1,  2,  3,  4,  5,  6, 13, 20, 27, 34, 41, 48,
              47, 46, 45, 44, 43, 42, 35, 28, 21, 14,  7,
               8,  9, 10, 11, 12, 19, 26, 33, 40, 39, 38, 37, 36, 29, 22, 15,
              16, 17, 18, 25, 32, 31, 30, 23, 24};
        load_frame(7, 7, 1, 8'ha5, 1'b1, 1'b0);
        drain(q, 8'ha5, 1'b1, q.size());
        data_out_rdy = 1'b1;
        check_idle();

        // Reset in the middle of a drain
        q = '{0, 1, 2, 3, 7, 11, 15, 14, 13, 12, 8, 4, 5, 6, 10, 9};
        load_frame(4, 4, 1, 8'h00, 1'b0, 1'b0);
        drain(q, 8'h00, 1'b0, 5);
        @(negedge clk);
        rst          = 1'b1;
        data_out_rdy = 1'b0;
        #1;
        check("midrst_valid", data_out_valid, 0);
        check("midrst_data", data_out, 0);
        check("midrst_last", data_out_last, 0);
        check("midrst_busy", busy, 0);
        check("midrst_rdy", data_in_rdy, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("postrst_busy", busy, 0);
        check("postrst_rdy", data_in_rdy, 1);

        // Zero row count in IDLE blocks input
        row           = 3'd0;
        col           = 3'd3;
        data_in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check("row0_rdy", data_in_rdy, 0);
            check("row0_busy", busy, 0);
        end
        data_in_valid = 1'b0;

        // Clean 2x2 clockwise frame after the reset
        q = '{0, 1, 3, 2};
        load_frame(2, 2, 1, 8'h00, 1'b0, 1'b0);
        drain(q, 8'h00, 1'b0, q.size());
        check_idle();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/spiral_reorder.md
# spiral_reorder

Parametrised matrix reorder buffer that accepts a row-major stream of up to (2^R_WIDTH−1)×(2^C_WIDTH−1) elements over a valid/ready handshake, stores one full frame, then replays it in one of four programmable orders: raster, clockwise spiral, counter-clockwise spiral or transpose. It is the next generation of the team's fixed clockwise spiral block, adding order selection, a frame-end marker and defined degenerate-dimension behaviour. It sits between a row-major producer and any consumer needing reordered traversal.

## Interface
- DATA_WIDTH, 8, element width in bits
- R_WIDTH, 3, row-count width; max rows = 2^R_WIDTH−1
- C_WIDTH, 3, column-count width; max cols = 2^C_WIDTH−1
- clk  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- row  in  R_WIDTH  frame row count, sampled on first accepted beat
- col  in  C_WIDTH  frame column count, sampled on first accepted beat
- mode  in  2  order: 0 raster, 1 clockwise spiral, 2 counter-clockwise spiral, 3 transpose (column-major); sampled with row/col
- data_in  in  DATA_WIDTH  input element, row-major
- data_in_valid  in  1  input beat valid
- data_in_rdy  out  1  block can accept an input beat
- data_out  out  DATA_WIDTH  reordered element
- data_out_valid  out  1  output beat valid
- data_out_rdy  in  1  consumer accepts output beat
- data_out_last  out  1  high with the final output beat of a frame
- busy  out  1  high in LOAD and DRAIN

## Operation
- Storage: flop array of (2^R_WIDTH−1)·(2^C_WIDTH−1) entries; address = r·col_q + c, width R_WIDTH+C_WIDTH.
- States: IDLE, LOAD, DRAIN.
- IDLE: data_in_rdy = 1 iff row≠0 and col≠0. On accept: latch row_q, col_q, mode_q, write entry 0; if row·col = 1 go to DRAIN, else LOAD.
- LOAD: data_in_rdy = 1; each accept writes the next row-major address; the accept of beat row_q·col_q−1 moves to DRAIN. row/col/mode ignored during LOAD and DRAIN.
- DRAIN: data_in_rdy = 0; address generator emits row_q·col_q beats in mode_q order; after the transfer with data_out_last, return to IDLE.
- Spiral: bounds top=0, bot=row_q−1, left=0, right=col_q−1. Clockwise: right along top, top++; down along right, right−−; left along bot if top≤bot, bot−−; up along left if left≤right, left++; repeat. Counter-clockwise: down along left, left++; right along bot, bot−−; up along right if left≤right, right−−; left along top if top≤bot, top++; repeat. Termination by output count, never by bound crossing.
- Transpose: c outer 0..col_q−1, r inner 0..row_q−1.
- Every stored element emitted exactly once per frame; no input/output overlap between frames.

## Timing
- Reset values: data_in_rdy 0 while rst high, then per IDLE rule; data_out 0, data_out_valid 0, data_out_last 0, busy 0, state IDLE, counters 0. Array contents need not reset.
- Input transfer on data_in_valid & data_in_rdy at rising edge.
- First data_out_valid in the cycle after the last input accept; one beat per cycle under data_out_rdy = 1.
- While data_out_valid & !data_out_rdy: data_out, data_out_last held stable, address generator frozen.
- data_out_valid drops the cycle after the last transfer; data_in_rdy rises in that same cycle (IDLE).
- Frame of N elements: N load cycles + N drain cycles minimum, zero bubbles.
- rst asserted mid-LOAD or mid-DRAIN: immediate return to IDLE with reset outputs; partial frame discarded; next frame starts clean.
- row=0 or col=0 in IDLE: data_in_rdy held 0, no state change.

## Test plan
- 4×4, mode 1, inputs 0..15 -> 0,1,2,3,7,11,15,14,13,12,8,4,5,6,10,9; last on 9; data_in_rdy high the next cycle.
- 4×4, mode 2, inputs 0..15 -> 0,4,8,12,13,14,15,11,7,3,2,1,5,9,10,6.
- 3×5 mode 1 inputs 0..14 -> 0,1,2,3,4,9,14,13,12,11,10,5,6,7,8; 4×1 mode 1 -> 0,1,2,3; 1×1 -> single beat with last.
- 2×3 mode 3, inputs 0..5 -> 0,3,1,4,2,5; mode 0 -> 0..5; row changed mid-LOAD has no effect.
- 7×7 mode 1 with random data_out_rdy and data_in_valid gaps -> 49 beats, exact spiral order, data_out stable while stalled, no drops or duplicates.
- rst pulsed at drain beat 5 of a 4×4 -> outputs 0 next cycle, state IDLE; following 2×2 mode 1 frame 0..3 -> 0,1,3,2; row=0 in IDLE -> data_in_rdy stays 0.
